i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//   I2S receiver: deserialises a stereo I2S stream (ADC side) into parallel signed
//   left/right sample pairs. It runs in the BCLK domain next to the I2S transmitter
//   and hands complete frames to the DSP core over a valid/ready handshake.
// PARAMETERS
//   DATA_WIDTH  16  captured bits per channel, MSB first; extra bits in a half-frame ignored
//   FRAME_BITS  26  expected BCLK cycles per half-frame (LR level period); checked only with macro
//   CNT_W       8   bit-counter width; counter saturates at 2**CNT_W-1
// PORTS
//   BCLK          in   1           bit clock; all logic on posedge
//   RESET         in   1           synchronous, active-high reset
//   ADC_LR_CLK    in   1           word select: 0 = left, 1 = right
//   ADC_DATA      in   1           serial data, MSB one BCLK after each LR edge
//   SAMPLE_L      out  DATA_WIDTH  signed left sample of the held frame
//   SAMPLE_R      out  DATA_WIDTH  signed right sample of the held frame
//   SAMPLE_VALID  out  1           held frame is valid
//   SAMPLE_READY  in   1           consumer accepts the frame when VALID&READY
//   OVERFLOW      out  1           1-cycle pulse: a completed frame was dropped
//   FRAME_ERR     out  1           1-cycle pulse: half-frame length error (macro only)
// BEHAVIOUR
//   - Interface decided: one clock BCLK; RESET synchronous, active-high.
//   - Reset: SAMPLE_L/R=0, SAMPLE_VALID=0, OVERFLOW=0, FRAME_ERR=0, lr_q=1, bit_cnt=0, state=SYNC.
//   - lr_q <= ADC_LR_CLK every cycle. Edge = ADC_LR_CLK != lr_q. In the edge cycle, ADC_DATA is
//     the previous word's LSB slot and is ignored; bit_cnt <= 0.
//   - Non-edge cycle: if bit_cnt < DATA_WIDTH, shift <= {shift[DATA_WIDTH-2:0], ADC_DATA}.
//     bit_cnt increments and saturates.
//   - FSM:
//     SYNC: wait for a falling LR edge (1->0), then go to LEFT. Rising edges are ignored.
//     LEFT: on the rising edge, if bit_cnt >= DATA_WIDTH, latch shift into left_hold and go
//       to RIGHT; else (short word) go to SYNC.
//     RIGHT: on the falling edge, if bit_cnt >= DATA_WIDTH, the frame completes and the FSM
//       goes to LEFT; else go to SYNC.
//   - Frame completion loads {left_hold, shift} into SAMPLE_L/R on the falling-edge clock.
//     SAMPLE_VALID=1 from the next cycle.
//   - Latency: SAMPLE_VALID rises 1 cycle after the first BCLK sampling the new left LR level.
//   - Handshake: VALID stays high and data stays stable until VALID&READY. Acceptance clears
//     VALID unless a new frame loads in the same cycle; then VALID stays 1 with the new data
//     and there is no overflow.
//   - If VALID=1, READY=0 and a frame completes: the new frame is dropped, the old frame is
//     kept, and OVERFLOW pulses 1 cycle.
//   - RESET mid-word discards all partial data. The first frame is only accepted after a full
//     SYNC->LEFT->RIGHT sequence.
// CONFIGURATION
//   I2S_RX_FRAME_CHECK_EN defined:
//     - At each edge in LEFT/RIGHT, the elapsed cycle count (bit_cnt+1) must equal FRAME_BITS.
//     - On mismatch: FRAME_ERR pulses 1 cycle, the FSM goes to SYNC, and that half-frame's
//       data is discarded.
//   Undefined: FRAME_ERR tied 0 and any half-frame length >= DATA_WIDTH+1 is accepted.
// STRUCTURE
//   Shared package i2s_pkg: DATA_WIDTH/FRAME_BITS defaults, and state encodings
//   SYNC=2'd0, LEFT=2'd1, RIGHT=2'd2, shared with the transmitter.
//   One sub-module, i2s_rx_shifter: bit counter plus shift register, with
//   clear-on-edge and saturation. The FSM and output register stay in i2s_rx.
// TESTING
//   1. Stream at 26 cycles/half, L=16'h8001, R=16'h7FFE, READY=1.
//      -> SAMPLE_L=16'h8001, SAMPLE_R=16'h7FFE, VALID 1 cycle per frame, 1 cycle after the falling edge.
//   2. Release RESET mid-right-word. -> No VALID until a full left+right pair is received;
//      the first output is the next complete frame.
//   3. READY=0 for 2 frames (L=1,R=2 then L=3,R=4).
//      -> Hold L=1,R=2; one OVERFLOW pulse; after READY, no stale second frame.
//   4. READY=1 in the same cycle the next frame completes.
//      -> VALID stays 1, data updates, OVERFLOW=0.
//   5. Left half shortened to 10 cycles.
//      -> Frame discarded and re-sync; the next frame is output correctly;
//         FRAME_ERR=1 only with I2S_RX_FRAME_CHECK_EN.
//   6. With the macro, a 27-cycle right half. -> FRAME_ERR pulse and no VALID for that frame;
//      without the macro the frame is accepted with its first 16 bits.

Source files
------------

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//   Constants and state encoding shared by the I2S receiver and transmitter.
//   Contents:
//     I2S_DATA_WIDTH  default captured bits per channel
//     I2S_FRAME_BITS  default BCLK cycles per half-frame (LR level period)
//     I2S_CNT_W       default bit-counter width
//     i2s_state_e     SYNC / LEFT / RIGHT framing states
//     half_len_ok()   half-frame length test used by the optional frame check
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 16;
    localparam int I2S_FRAME_BITS = 26;
    localparam int I2S_CNT_W      = 8;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    // bit_cnt is cleared in the edge cycle, so the number of cycles spent at
    // the previous LR level is one more than the counter value seen at the edge.
    function automatic logic half_len_ok(input int bit_cnt, input int frame_bits);
        return (bit_cnt + 1) == frame_bits;
    endfunction

endpackage

// File: rtl/i2s_rx_shifter.sv
// -----------------------------------------------------------------------------
// i2s_rx_shifter
//   Serial-to-parallel front end of the I2S receiver: a bit counter that is
//   cleared in every LR edge cycle and saturates at its maximum, plus an
//   MSB-first shift register that stops after DATA_WIDTH bits.
// Ports:
//   clk_i      in   1           bit clock (BCLK)
//   rst_i      in   1           synchronous, active-high reset
//   edge_i     in   1           LR edge in this cycle; data bit is ignored
//   data_i     in   1           serial data bit
//   bit_cnt_o  out  CNT_W       bits seen since the last LR edge
//   shift_o    out  DATA_WIDTH  captured word, last bit in the LSB
// -----------------------------------------------------------------------------
module i2s_rx_shifter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int CNT_W      = I2S_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  edge_i,
    input  logic                  data_i,
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic [DATA_WIDTH-1:0] shift_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (edge_i) begin
            // The edge-cycle bit belongs to the previous word's LSB slot.
            bit_cnt_q <= '0;
        end else begin
            // Bits beyond DATA_WIDTH in a long half-frame are dropped.
            if (int'(bit_cnt_q) < DATA_WIDTH) begin
                shift_q <= {shift_q[DATA_WIDTH-2:0], data_i};
            end
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_cnt_o = bit_cnt_q;
    assign shift_o   = shift_q;

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
//   I2S receiver (ADC side). Deserialises a stereo I2S stream into signed
//   left/right sample pairs and presents each complete frame on a
//   valid/ready handshake. Everything runs on posedge BCLK.
//
//   Build option: define I2S_RX_FRAME_CHECK_EN to require every half-frame to
//   last exactly FRAME_BITS cycles; a mismatch pulses FRAME_ERR, discards the
//   half-frame and re-synchronises. Without it FRAME_ERR stays 0 and any
//   half-frame of at least DATA_WIDTH+1 cycles is accepted.
//
// Ports:
//   BCLK          in   1           bit clock
//   RESET         in   1           synchronous, active-high reset
//   ADC_LR_CLK    in   1           word select: 0 = left, 1 = right
//   ADC_DATA      in   1           serial data, MSB one BCLK after each LR edge
//   SAMPLE_L      out  DATA_WIDTH  signed left sample of the held frame
//   SAMPLE_R      out  DATA_WIDTH  signed right sample of the held frame
//   SAMPLE_VALID  out  1           held frame is valid
//   SAMPLE_READY  in   1           consumer takes the frame when VALID&READY
//   OVERFLOW      out  1           1-cycle pulse: a completed frame was dropped
//   FRAME_ERR     out  1           1-cycle pulse: half-frame length error
//
// state | meaning
// ------+----------------------------------------------------------------
// SYNC  | waiting for a falling LR edge to start a left word
// LEFT  | receiving the left word; rising edge closes it
// RIGHT | receiving the right word; falling edge completes the frame
// -----------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int FRAME_BITS = I2S_FRAME_BITS,
    parameter int CNT_W      = I2S_CNT_W
) (
    input  logic                         BCLK,
    input  logic                         RESET,
    input  logic                         ADC_LR_CLK,
    input  logic                         ADC_DATA,
    output logic signed [DATA_WIDTH-1:0] SAMPLE_L,
    output logic signed [DATA_WIDTH-1:0] SAMPLE_R,
    output logic                         SAMPLE_VALID,
    input  logic                         SAMPLE_READY,
    output logic                         OVERFLOW,
    output logic                         FRAME_ERR
);

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    i2s_state_e            state_q;
    logic                  lr_q;
    logic [DATA_WIDTH-1:0] left_hold_q;
    logic [DATA_WIDTH-1:0] sample_l_q;
    logic [DATA_WIDTH-1:0] sample_r_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  frame_err_q;

    logic                  lr_edge;
    logic                  rise_edge;
    logic                  fall_edge;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  word_full;
    logic                  len_bad;

    assign lr_edge   = ADC_LR_CLK != lr_q;
    assign rise_edge = lr_edge &&  ADC_LR_CLK;
    assign fall_edge = lr_edge && !ADC_LR_CLK;

    i2s_rx_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_shifter (
        .clk_i      (BCLK),
        .rst_i      (RESET),
        .edge_i     (lr_edge),
        .data_i     (ADC_DATA),
        .bit_cnt_o  (bit_cnt),
        .shift_o    (shift)
    );

    assign word_full = int'(bit_cnt) >= DATA_WIDTH;
    // Constant-false when the frame check is not built in.
    assign len_bad   = FRAME_CHECK && !half_len_ok(int'(bit_cnt), FRAME_BITS);

    always_ff @(posedge BCLK) begin
        if (RESET) begin
            state_q     <= SYNC;
            lr_q        <= 1'b1;
            left_hold_q <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            lr_q        <= ADC_LR_CLK;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // Acceptance; a frame completing in this same cycle re-sets VALID below.
            if (valid_q && SAMPLE_READY) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                SYNC: begin
                    if (fall_edge) begin
                        state_q <= LEFT;
                    end
                end
                LEFT: begin
                    if (rise_edge) begin
                        if (len_bad) begin
                            frame_err_q <= 1'b1;
                            state_q     <= SYNC;
                        end else if (word_full) begin
                            left_hold_q <= shift;
                            state_q     <= RIGHT;
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                end
                RIGHT: begin
                    if (fall_edge) begin
                        if (len_bad) begin
                            frame_err_q <= 1'b1;
                            state_q     <= SYNC;
                        end else if (word_full) begin
                            // This falling edge already starts the next left word.
                            state_q <= LEFT;
                            if (valid_q && !SAMPLE_READY) begin
                                overflow_q <= 1'b1;
                            end else begin
                                sample_l_q <= left_hold_q;
                                sample_r_q <= shift;
                                valid_q    <= 1'b1;
                            end
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    assign SAMPLE_L     = sample_l_q;
    assign SAMPLE_R     = sample_r_q;
    assign SAMPLE_VALID = valid_q;
    assign OVERFLOW     = overflow_q;
    assign FRAME_ERR    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

    logic        BCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ADC_LR_CLK = 1'b1;
    logic        ADC_DATA = 1'b0;
    logic        SAMPLE_READY = 1'b1;
    logic [15:0] SAMPLE_L;
    logic [15:0] SAMPLE_R;
    logic        SAMPLE_VALID;
    logic        OVERFLOW;
    logic        FRAME_ERR;

    int errors = 0;
    int checks = 0;

    i2s_rx dut (
        .BCLK         (BCLK),
        .RESET        (RESET),
        .ADC_LR_CLK   (ADC_LR_CLK),
        .ADC_DATA     (ADC_DATA),
        .SAMPLE_L     (SAMPLE_L),
        .SAMPLE_R     (SAMPLE_R),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .OVERFLOW     (OVERFLOW),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 BCLK = ~BCLK;

    // Cycle counter and observation of the output side, half a cycle after
    // each active edge.
    int cyc = 0;
    always @(posedge BCLK) cyc <= cyc + 1;

    int          fall_cyc = 0;
    int          lat_last = -1;
    int          valid_hi = 0;
    int          ovf_cnt = 0;
    int          ferr_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] acc_l[$];
    logic [15:0] acc_r[$];

    always begin
        @(negedge BCLK);
        #1;
        if (SAMPLE_VALID === 1'b1) begin
            valid_hi = valid_hi + 1;
            if (prev_valid !== 1'b1) lat_last = cyc - fall_cyc;
            if (SAMPLE_READY === 1'b1) begin
                acc_l.push_back(SAMPLE_L);
                acc_r.push_back(SAMPLE_R);
            end
        end
        if (OVERFLOW === 1'b1) ovf_cnt = ovf_cnt + 1;
        if (FRAME_ERR === 1'b1) ferr_cnt = ferr_cnt + 1;
        prev_valid = SAMPLE_VALID;
    end

    task automatic drive_cycle(input logic lr, input logic d);
        @(negedge BCLK);
        if (ADC_LR_CLK === 1'b1 && lr === 1'b0) fall_cyc = cyc;
        ADC_LR_CLK = lr;
        ADC_DATA   = d;
    endtask

    // One half-frame of n cycles: edge slot and filler bits are driven as 1
    // so that they corrupt the result if they are not ignored.
    task automatic send_half(input logic lr, input logic [15:0] word, input int n, input int rel);
        logic d;
        for (int i = 0; i < n; i++) begin
            d = (i >= 1 && i <= 16) ? word[16-i] : 1'b1;
            drive_cycle(lr, d);
            if (i == rel) RESET = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr);
        send_half(1'b0, l, nl, -1);
        send_half(1'b1, r, nr, -1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) drive_cycle(1'b1, 1'b0);
        RESET = 1'b0;
        drive_cycle(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (SAMPLE_L !== 16'h0000) begin errors++; $display("FAIL reset_l got=%h exp=0000", SAMPLE_L); end
        checks++; if (SAMPLE_R !== 16'h0000) begin errors++; $display("FAIL reset_r got=%h exp=0000", SAMPLE_R); end
        checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", SAMPLE_VALID); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", FRAME_ERR); end
    endtask

    task automatic test_stream();
        int a0, v0, o0;
        do_reset();
        SAMPLE_READY = 1'b1;
        a0 = acc_l.size(); v0 = valid_hi; o0 = ovf_cnt;
        send_frame(16'h8001, 16'h7FFE, 26, 26);
        send_frame(16'h0000, 16'hFFFF, 26, 26);
        send_frame(16'h5A5A, 16'hA5C3, 26, 26);
        send_half(1'b0, 16'h0000, 6, -1);
        checks++; if (acc_l.size() - a0 !== 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", acc_l.size() - a0); end
        else begin
            checks++; if (acc_l[a0] !== 16'h8001 || acc_r[a0] !== 16'h7FFE) begin errors++; $display("FAIL stream_f0 got=%h/%h exp=8001/7ffe", acc_l[a0], acc_r[a0]); end
            checks++; if (acc_l[a0+1] !== 16'h0000 || acc_r[a0+1] !== 16'hFFFF) begin errors++; $display("FAIL stream_f1 got=%h/%h exp=0000/ffff", acc_l[a0+1], acc_r[a0+1]); end
            checks++; if (acc_l[a0+2] !== 16'h5A5A || acc_r[a0+2] !== 16'hA5C3) begin errors++; $display("FAIL stream_f2 got=%h/%h exp=5a5a/a5c3", acc_l[a0+2], acc_r[a0+2]); end
        end
        checks++; if (valid_hi - v0 !== 3) begin errors++; $display("FAIL stream_valid_cycles got=%0d exp=3", valid_hi - v0); end
        checks++; if (lat_last !== 1) begin errors++; $display("FAIL stream_latency got=%0d exp=1", lat_last); end
        checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL stream_ovf got=%0d exp=0", ovf_cnt - o0); end
    endtask

    task automatic test_reset_mid_word();
        int a0, v0;
        SAMPLE_READY = 1'b1;
        RESET = 1'b1;
        v0 = valid_hi;
        send_half(1'b0, 16'h1111, 26, -1);
        send_half(1'b1, 16'h2222, 26, 10);
        a0 = acc_l.size();
        send_frame(16'h3333, 16'h4444, 26, 26);
        checks++; if (valid_hi - v0 !== 0) begin errors++; $display("FAIL rstmid_early_valid got=%0d exp=0", valid_hi - v0); end
        send_frame(16'h5555, 16'h6666, 26, 26);
        send_half(1'b0, 16'h0000, 6, -1);
        checks++; if (acc_l.size() - a0 !== 2) begin errors++; $display("FAIL rstmid_count got=%0d exp=2", acc_l.size() - a0); end
        else begin
            checks++; if (acc_l[a0] !== 16'h3333 || acc_r[a0] !== 16'h4444) begin errors++; $display("FAIL rstmid_first got=%h/%h exp=3333/4444", acc_l[a0], acc_r[a0]); end
        end
    endtask

    task automatic test_backpressure();
        int a0, o0;
        do_reset();
        SAMPLE_READY = 1'b0;
        a0 = acc_l.size(); o0 = ovf_cnt;
        send_frame(16'h0001, 16'h0002, 26, 26);
        send_frame(16'h0003, 16'h0004, 26, 26);
        send_half(1'b0, 16'h0000, 8, -1);
        #1;
        checks++; if (SAMPLE_VALID !== 1'b1 || SAMPLE_L !== 16'h0001 || SAMPLE_R !== 16'h0002) begin errors++; $display("FAIL bp_hold got=%b %h/%h exp=1 0001/0002", SAMPLE_VALID, SAMPLE_L, SAMPLE_R); end
        checks++; if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL bp_ovf got=%0d exp=1", ovf_cnt - o0); end
        SAMPLE_READY = 1'b1;
        send_half(1'b0, 16'h0000, 8, -1);
        #1;
        checks++; if (acc_l.size() - a0 !== 1) begin errors++; $display("FAIL bp_count got=%0d exp=1", acc_l.size() - a0); end
        else begin
            checks++; if (acc_l[a0] !== 16'h0001 || acc_r[a0] !== 16'h0002) begin errors++; $display("FAIL bp_data got=%h/%h exp=0001/0002", acc_l[a0], acc_r[a0]); end
        end
        checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL bp_stale got=%b exp=0", SAMPLE_VALID); end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        do_reset();
        SAMPLE_READY = 1'b0;
        a0 = acc_l.size(); o0 = ovf_cnt;
        send_frame(16'h1234, 16'h5678, 26, 26);
        send_frame(16'h9ABC, 16'hDEF0, 26, 26);
        // Edge cycle completing the second frame, with READY raised together.
        drive_cycle(1'b0, 1'b1);
        SAMPLE_READY = 1'b1;
        @(posedge BCLK);
        #1;
        checks++; if (SAMPLE_VALID !== 1'b1 || SAMPLE_L !== 16'h9ABC || SAMPLE_R !== 16'hDEF0) begin errors++; $display("FAIL b2b_update got=%b %h/%h exp=1 9abc/def0", SAMPLE_VALID, SAMPLE_L, SAMPLE_R); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL b2b_ovf_now got=%b exp=0", OVERFLOW); end
        send_half(1'b0, 16'h0000, 5, -1);
        checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_ovf got=%0d exp=0", ovf_cnt - o0); end
        checks++; if (acc_l.size() - a0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", acc_l.size() - a0); end
        else begin
            checks++; if (acc_l[a0] !== 16'h1234 || acc_l[a0+1] !== 16'h9ABC) begin errors++; $display("FAIL b2b_order got=%h,%h exp=1234,9abc", acc_l[a0], acc_l[a0+1]); end
        end
    endtask

    task automatic test_short_left();
        int a0, f0, exp_ferr;
`ifdef I2S_RX_FRAME_CHECK_EN
        exp_ferr = 1;
`else
        exp_ferr = 0;
`endif
        do_reset();
        SAMPLE_READY = 1'b1;
        a0 = acc_l.size(); f0 = ferr_cnt;
        send_frame(16'h1357, 16'h2468, 26, 26);
        send_frame(16'hAAAA, 16'h5555, 10, 26);
        send_frame(16'h0F0F, 16'hF0F0, 26, 26);
        send_half(1'b0, 16'h0000, 6, -1);
        checks++; if (acc_l.size() - a0 !== 2) begin errors++; $display("FAIL short_count got=%0d exp=2", acc_l.size() - a0); end
        else begin
            checks++; if (acc_l[a0] !== 16'h1357 || acc_r[a0] !== 16'h2468) begin errors++; $display("FAIL short_f0 got=%h/%h exp=1357/2468", acc_l[a0], acc_r[a0]); end
            checks++; if (acc_l[a0+1] !== 16'h0F0F || acc_r[a0+1] !== 16'hF0F0) begin errors++; $display("FAIL short_f1 got=%h/%h exp=0f0f/f0f0", acc_l[a0+1], acc_r[a0+1]); end
        end
        checks++; if (ferr_cnt - f0 !== exp_ferr) begin errors++; $display("FAIL short_ferr got=%0d exp=%0d", ferr_cnt - f0, exp_ferr); end
    endtask

    task automatic test_long_right();
        int a0, f0, exp_n, exp_ferr;
        logic [15:0] exp_l[4];
        logic [15:0] exp_r[4];
`ifdef I2S_RX_FRAME_CHECK_EN
        exp_n = 2; exp_ferr = 1;
        exp_l[0] = 16'h0101; exp_r[0] = 16'h0202;
        exp_l[1] = 16'h7777; exp_r[1] = 16'h8888;
        exp_l[2] = 16'h0000; exp_r[2] = 16'h0000;
        exp_l[3] = 16'h0000; exp_r[3] = 16'h0000;
`else
        exp_n = 4; exp_ferr = 0;
        exp_l[0] = 16'h0101; exp_r[0] = 16'h0202;
        exp_l[1] = 16'hC3C3; exp_r[1] = 16'h3C3C;
        exp_l[2] = 16'h4D2E; exp_r[2] = 16'hB1F0;
        exp_l[3] = 16'h7777; exp_r[3] = 16'h8888;
`endif
        do_reset();
        SAMPLE_READY = 1'b1;
        a0 = acc_l.size(); f0 = ferr_cnt;
        send_frame(16'h0101, 16'h0202, 26, 26);
        send_frame(16'hC3C3, 16'h3C3C, 26, 27);
        send_frame(16'h4D2E, 16'hB1F0, 26, 26);
        send_frame(16'h7777, 16'h8888, 26, 26);
        send_half(1'b0, 16'h0000, 6, -1);
        checks++; if (ferr_cnt - f0 !== exp_ferr) begin errors++; $display("FAIL long_ferr got=%0d exp=%0d", ferr_cnt - f0, exp_ferr); end
        checks++; if (acc_l.size() - a0 !== exp_n) begin errors++; $display("FAIL long_count got=%0d exp=%0d", acc_l.size() - a0, exp_n); end
        else begin
            for (int k = 0; k < exp_n; k++) begin
                checks++;
                if (acc_l[a0+k] !== exp_l[k] || acc_r[a0+k] !== exp_r[k]) begin
                    errors++;
                    $display("FAIL long_f%0d got=%h/%h exp=%h/%h", k, acc_l[a0+k], acc_r[a0+k], exp_l[k], exp_r[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_mid_word();
        test_backpressure();
        test_back_to_back();
        test_short_left();
        test_long_right();
        repeat (2) @(negedge BCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
